// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, ALU commands,
// instruction field constants and the data-processing command decoder.
package multicycle_control_unit_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    typedef struct packed {
        logic       valid;
        logic       writes;
        logic       arith;
        logic [2:0] alu;
    } cmd_info_t;

    // arith marks the commands whose C and V results are meaningful
    function automatic cmd_info_t decode_cmd(input logic [3:0] cmd, input logic eor_en);
        cmd_info_t info;
        info = '0;
        case (cmd)
            CMD_ADD: info = '{valid: 1'b1, writes: 1'b1, arith: 1'b1, alu: ALU_ADD};
            CMD_SUB: info = '{valid: 1'b1, writes: 1'b1, arith: 1'b1, alu: ALU_SUB};
            CMD_AND: info = '{valid: 1'b1, writes: 1'b1, arith: 1'b0, alu: ALU_AND};
            CMD_ORR: info = '{valid: 1'b1, writes: 1'b1, arith: 1'b0, alu: ALU_ORR};
            CMD_EOR: info = '{valid: eor_en, writes: eor_en, arith: 1'b0, alu: ALU_EOR};
            CMD_CMP: info = '{valid: 1'b1, writes: 1'b0, arith: 1'b1, alu: ALU_SUB};
            CMD_CMN: info = '{valid: 1'b1, writes: 1'b0, arith: 1'b1, alu: ALU_ADD};
            CMD_TST: info = '{valid: 1'b1, writes: 1'b0, arith: 1'b0, alu: ALU_AND};
            default: info = '0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_cond_eval.sv
// Combinational evaluation of an ARM condition code against the NZCV flags.
module cond_eval (
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       cond_ex_o
);
    logic n, z, c, v, ge;

    assign {n, z, c, v} = nzcv_i;
    assign ge = (n == v);

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            4'b0000: cond_ex_o = z;
            4'b0001: cond_ex_o = ~z;
            4'b0010: cond_ex_o = c;
            4'b0011: cond_ex_o = ~c;
            4'b0100: cond_ex_o = n;
            4'b0101: cond_ex_o = ~n;
            4'b0110: cond_ex_o = v;
            4'b0111: cond_ex_o = ~v;
            4'b1000: cond_ex_o = c & ~z;
            4'b1001: cond_ex_o = ~c | z;
            4'b1010: cond_ex_o = ge;
            4'b1011: cond_ex_o = ~ge;
            4'b1100: cond_ex_o = ~z & ge;
            4'b1101: cond_ex_o = z | ~ge;
            4'b1110: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;  // 1111 is never executed
        endcase
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle ARM-subset control unit: FSM, main decoder and NZCV flag register.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int ALU_CTRL_W = 3,
    parameter int EOR_EN     = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           Instr,
    input  logic [3:0]            ALUFlags,
    input  logic                  MemReady,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  RegWrite,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ImmSrc,
    output logic [1:0]            RegSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  IllegalInstr,
    output logic [3:0]            State
);
    state_e     state_q, state_d;
    logic [3:0] nzcv_q, nzcv_d;
    logic       condexr_q, condexr_d;

    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd, rd, cond;
    logic       s_bit, s_eff, cond_ex;
    cmd_info_t  info;
    logic       unused_bits;

    logic       pcw, irw, regw, memw, illegal;
    logic [2:0] alu_sel;

    assign cond  = Instr[31:28];
    assign op    = Instr[27:26];
    assign funct = Instr[25:20];
    assign rd    = Instr[15:12];
    assign cmd   = funct[4:1];
    assign s_bit = funct[0];
    assign unused_bits = ^{Instr[19:16], Instr[11:0]};

    assign info  = decode_cmd(cmd, EOR_EN != 0);
    // compare/test commands exist only to set flags
    assign s_eff = s_bit | (info.valid & ~info.writes);

    cond_eval u_cond_eval (
        .cond_i    (cond),
        .nzcv_i    (nzcv_q),
        .cond_ex_o (cond_ex)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_FETCH;
            nzcv_q    <= 4'b0000;
            condexr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            nzcv_q    <= nzcv_d;
            condexr_q <= condexr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        nzcv_d    = nzcv_q;
        condexr_d = condexr_q;
        pcw       = 1'b0;
        irw       = 1'b0;
        regw      = 1'b0;
        memw      = 1'b0;
        illegal   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        alu_sel   = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (MemReady) begin
                    irw     = 1'b1;
                    pcw     = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                condexr_d = cond_ex;
                state_d   = S_FETCH;
                if (cond_ex) begin
                    case (op)
                        OP_DP: begin
                            if (!info.valid) illegal = 1'b1;
                            else state_d = funct[5] ? S_EXECI : S_EXECR;
                        end
                        OP_MEM:  state_d = S_MEMADR;
                        OP_BR:   state_d = S_BRANCH;
                        default: illegal = 1'b1;
                    endcase
                end
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                alu_sel = info.alu;
                state_d = S_ALUWB;
                if (s_eff && condexr_q) begin
                    nzcv_d[3:2] = ALUFlags[3:2];
                    if (info.arith) nzcv_d[1:0] = ALUFlags[1:0];
                end
            end
            S_ALUWB: begin
                regw    = condexr_q & info.writes;
                pcw     = condexr_q & info.writes & (rd == 4'd15);
                state_d = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                alu_sel = funct[3] ? ALU_ADD : ALU_SUB;
                state_d = funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                regw      = condexr_q;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                memw   = condexr_q;
                if (MemReady) state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pcw       = condexr_q;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // strobes are forced low combinationally so reset silences them at once
    assign PCWrite      = pcw & ~RESET;
    assign IRWrite      = irw & ~RESET;
    assign RegWrite     = regw & ~RESET;
    assign MemWrite     = memw & ~RESET;
    assign IllegalInstr = illegal & ~RESET;

    assign ALUControl = ALU_CTRL_W'(alu_sel);
    assign ImmSrc     = op;
    assign RegSrc     = {(op == OP_MEM) & ~funct[0], op == OP_BR};
    assign State      = state_q;
endmodule
